// File: rtl/stage_mem_pkg.sv
// rtl/stage_mem_pkg.sv - shared funct3 encodings and FSM states for the memory stage
package stage_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUS  = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_byte_access(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half_access(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/stage_mem_if.sv
// rtl/stage_mem_if.sv - Wishbone-classic data port between the memory stage and the bus
interface stage_mem_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] wbm_addr_o;
    logic [31:0]       wbm_dat_o;
    logic [3:0]        wbm_sel_o;
    logic              wbm_we_o;
    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic [31:0]       wbm_dat_i;
    logic              wbm_ack_i;

    modport master (
        output wbm_addr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_addr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/stage_mem_lsu_align.sv
// rtl/stage_mem_lsu_align.sv - misalignment detect, store lane shaping, load extract/extend
module lsu_align
    import stage_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_st_dat,
    input  logic [31:0] i_ld_raw,
    output logic        o_misaligned,
    output logic [3:0]  o_sel,
    output logic [31:0] o_st_dat,
    output logic [31:0] o_ld_dat
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_ld_raw[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_ld_raw[15:8];
            2'd2:    w_byte = i_ld_raw[23:16];
            2'd3:    w_byte = i_ld_raw[31:24];
            default: w_byte = i_ld_raw[7:0];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];

    // Reserved funct3 codes fall into the word branch.
    always_comb begin
        o_misaligned = 1'b0;
        o_sel        = 4'b1111;
        o_st_dat     = i_st_dat;
        o_ld_dat     = i_ld_raw;
        if (is_byte_access(i_funct3)) begin
            o_sel    = 4'b0001 << i_addr_lo;
            o_st_dat = {4{i_st_dat[7:0]}};
            o_ld_dat = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
        end else if (is_half_access(i_funct3)) begin
            o_misaligned = i_addr_lo[0];
            o_sel        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_st_dat     = {2{i_st_dat[15:0]}};
            o_ld_dat     = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
        end else begin
            o_misaligned = |i_addr_lo;
        end
    end

endmodule

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - memory-access stage with Wishbone data master; MEM_TIMEOUT_EN adds bus timeout
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        is_ld_inst_i,
    input  logic        is_st_inst_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_dat_i,
    output logic [31:0] dat_o,
    output logic        stall_o,
    output logic        e_ld_addr_mis_o,
    output logic        e_st_addr_mis_o,
`ifdef MEM_TIMEOUT_EN
    output logic        e_access_fault_o,
`endif
    stage_mem_if.master wbm
);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_dat;
    logic [3:0]        r_sel;
    logic              r_we;
    logic              r_cyc;
    logic [31:0]       r_ld_dat;

    logic        w_is_ld;
    logic        w_is_st;
    logic        w_req;
    logic        w_mis;
    logic        w_start;
    logic        w_timeout;
    logic        w_fault;
    logic [3:0]  w_sel;
    logic [31:0] w_st_dat;
    logic [31:0] w_ld_dat;
    logic [31:0] w_word_addr;

    // A load wins when both decode flags are set.
    assign w_is_ld     = is_ld_inst_i;
    assign w_is_st     = is_st_inst_i & ~is_ld_inst_i;
    assign w_req       = valid_i & (is_ld_inst_i | is_st_inst_i);
    assign w_start     = (r_state == MEM_IDLE) & w_req & ~w_mis;
    assign w_word_addr = {addr_i[31:2], 2'b00};

    lsu_align u_align (
        .i_funct3     (funct3_i),
        .i_addr_lo    (addr_i[1:0]),
        .i_st_dat     (st_dat_i),
        .i_ld_raw     (wbm.wbm_dat_i),
        .o_misaligned (w_mis),
        .o_sel        (w_sel),
        .o_st_dat     (w_st_dat),
        .o_ld_dat     (w_ld_dat)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_fault;

    assign w_timeout = (r_state == MEM_BUS) & ~wbm.wbm_ack_i &
                       (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_tmo_cnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            if (r_state == MEM_BUS) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end else if (r_state == MEM_DONE) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign w_fault          = (r_state == MEM_DONE) & r_fault;
    assign e_access_fault_o = w_fault;
`else
    // The timeout depth only matters when the counter is built.
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
    assign w_fault      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        stall_o         = 1'b0;
        e_ld_addr_mis_o = 1'b0;
        e_st_addr_mis_o = 1'b0;
        dat_o           = addr_i;
        case (r_state)
            MEM_IDLE: begin
                if (w_req) begin
                    if (w_mis) begin
                        e_ld_addr_mis_o = w_is_ld;
                        e_st_addr_mis_o = w_is_st;
                    end else begin
                        stall_o     = 1'b1;
                        w_state_nxt = MEM_BUS;
                    end
                end
            end
            MEM_BUS: begin
                stall_o = 1'b1;
                if (wbm.wbm_ack_i || w_timeout) begin
                    w_state_nxt = MEM_DONE;
                end
            end
            MEM_DONE: begin
                w_state_nxt = MEM_IDLE;
                if (w_fault) begin
                    dat_o = 32'h0;
                end else if (!r_we) begin
                    dat_o = r_ld_dat;
                end
            end
            default: w_state_nxt = MEM_IDLE;
        endcase
    end

    // Request attributes are latched on entry to BUS and held until the cycle ends.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_addr   <= '0;
            r_dat    <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_cyc    <= 1'b0;
            r_ld_dat <= '0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    if (w_start) begin
                        r_cyc  <= 1'b1;
                        r_addr <= w_word_addr[ADDR_W-1:0];
                        r_sel  <= w_sel;
                        r_we   <= w_is_st;
                        r_dat  <= w_is_st ? w_st_dat : 32'h0;
                    end
                end
                MEM_BUS: begin
                    if (wbm.wbm_ack_i) begin
                        r_cyc    <= 1'b0;
                        r_ld_dat <= w_ld_dat;
                    end else if (w_timeout) begin
                        r_cyc    <= 1'b0;
                        r_ld_dat <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbm.wbm_addr_o = r_addr;
    assign wbm.wbm_dat_o  = r_dat;
    assign wbm.wbm_sel_o  = r_sel;
    assign wbm.wbm_we_o   = r_we;
    assign wbm.wbm_cyc_o  = r_cyc;
    assign wbm.wbm_stb_o  = r_cyc;

endmodule
